mux4_arbiter: RTL

Round-robin arbiter that shares one downstream resource (memory/bus port) among four requesters and steers the granted requester's payload through a 4:1 select onto a single output. It sits between up to four masters (fetch, load/store, debug, DMA) and the shared port. A grant is held until the resource signals completion or a timeout fires.

---
 rtl/mux4_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: shares one downstream port among four requesters.
// A grant is held until `done` or until TIMEOUT cycles pass without it, and the
// granted requester's payload is steered onto out_data.
// Build option: define MUX4_ARBITER_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, port 0 has the highest fixed priority and port 3 the lowest.
module mux4_arbiter #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [BITS-1:0] d1,
  input  logic [BITS-1:0] d2,
  input  logic [BITS-1:0] d3,
  input  logic [BITS-1:0] d4,
  input  logic            done,
  output logic [3:0]      gnt,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_reg;
  // sel_reg also serves as the "last granted port": it is only rewritten on a
  // new grant, and on release last must equal sel, so a second register would
  // always hold the same value. It resets to 3 so port 0 is scanned first.
  logic [1:0]      sel_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      gnt_reg;
  logic            valid_reg;
  logic            timeout_reg;

  logic [BITS-1:0] dsel [4];
  logic [1:0]      cand [4];
  logic [3:0]      hit;
  logic            win_any;
  logic [1:0]      win_idx;
  logic            expire;
  logic            end_grant;

  assign dsel[0] = d1;
  assign dsel[1] = d2;
  assign dsel[2] = d3;
  assign dsel[3] = d4;

  // cand[k] is the port examined at scan position k; hit[k] says it requests.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
`ifdef MUX4_ARBITER_ROUND_ROBIN_EN
      assign cand[gi] = sel_reg + 2'(gi + 1);
`else
      assign cand[gi] = 2'(gi);
`endif
      assign hit[gi] = req[cand[gi]];
    end
  endgenerate

  // Winner is the requesting port at the earliest scan position.
  always_comb begin
    win_any = |hit;
    win_idx = cand[0];
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) win_idx = cand[i];
    end
  end

  assign expire    = (cnt_reg == CNT_LAST);
  assign end_grant = done || expire;

  // Grant FSM: IDLE waits for any request; BUSY holds the grant until done or
  // expiry, then re-arbitrates in the same cycle so back-to-back grants have no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      sel_reg     <= 2'd3;
      cnt_reg     <= '0;
      gnt_reg     <= 4'b0000;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            state_reg <= BUSY;
            sel_reg   <= win_idx;
            gnt_reg   <= 4'b0001 << win_idx;
            valid_reg <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          if (end_grant) begin
            // done wins over a simultaneous expiry: no timeout pulse then.
            timeout_reg <= !done;
            cnt_reg     <= '0;
            if (win_any) begin
              sel_reg   <= win_idx;
              gnt_reg   <= 4'b0001 << win_idx;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 4'b0000;
              valid_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'b0000;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign out_valid = valid_reg;
  assign timeout   = timeout_reg;
  assign out_data  = valid_reg ? dsel[sel_reg] : '0;

endmodule
